// File: rtl/mem_write_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_write_ctrl_pkg
// Description : Shared definitions for the UART-driven RAM write path:
//               write-controller state encoding, host command bytes and the
//               default inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_write_ctrl_pkg;

   // Write-controller states
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_ADDR = 3'd1,
      S_GET_LEN  = 3'd2,
      S_GET_DATA = 3'd3,
      S_DONE     = 3'd4,
      S_REARM    = 3'd5
   } state_t;

   // Command bytes decoded by the main control FSM
   localparam logic [7:0] CMD_WR = 8'h0F;
   localparam logic [7:0] CMD_RD = 8'hF0;

   // 100 ms at 50 MHz
   localparam int DEFAULT_TIMEOUT_CYC = 5_000_000;

endpackage
`default_nettype wire

// File: rtl/mem_write_ctrl_byte_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : byte_timeout
// Description : Inter-byte inactivity watchdog. Reloaded on every accepted
//               byte (or frame start), counts down while enabled, and flags
//               expiry so that the owner's registered done/err outputs land
//               exactly TIMEOUT_CYC cycles after the last reload.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout
   import mem_write_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   // Expiry is raised three counts early: one for the reload cycle, one for
   // the DONE state and one for the registered done_wr behind it.
   localparam logic [CNT_W-1:0] FIRE_AT  = CNT_W'(3);

   logic [CNT_W-1:0] count;

   // Reload on activity, otherwise count down while the owner is waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign expired = en && (count == FIRE_AT);

endmodule
`default_nettype wire

// File: rtl/mem_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_write_ctrl
// Description : Receives an ADDR / LEN / payload frame from the UART while
//               start_wr is held and writes the payload into the byte RAM at
//               consecutive (wrapping) addresses. Signals completion with a
//               one-cycle done_wr, flagged with err_wr on inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_ctrl
   import mem_write_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_wr,
   input  logic              rxrdy,
   input  logic [7:0]        rxdw,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              done_wr,
   output logic              err_wr
);

   state_t            state, next_state;
   logic [ADDR_W-1:0] ptr, ptr_next, addr_byte;
   logic [8:0]        remaining, remaining_next;
   logic              timed_out, timed_out_next;
   logic              mem_we_next, done_next, err_next;
   logic [ADDR_W-1:0] mem_addr_next;
   logic [7:0]        mem_din_next;
   logic              active, take, tmo_load, expired;

   // Address byte resized to the RAM address width
   if (ADDR_W > 8) begin : g_addr_zext
      assign addr_byte = {{(ADDR_W-8){1'b0}}, rxdw};
   end else if (ADDR_W == 8) begin : g_addr_same
      assign addr_byte = rxdw;
   end else begin : g_addr_trunc
      assign addr_byte = rxdw[ADDR_W-1:0];
   end

   assign active   = (state == S_GET_ADDR) || (state == S_GET_LEN) || (state == S_GET_DATA);
   assign take     = active && start_wr && rxrdy;
   assign tmo_load = ((state == S_IDLE) && start_wr) || take;

   byte_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .load    (tmo_load),
      .en      (active),
      .expired (expired)
   );

   // State register plus registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         remaining <= '0;
         timed_out <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         done_wr   <= 1'b0;
         err_wr    <= 1'b0;
      end else begin
         state     <= next_state;
         ptr       <= ptr_next;
         remaining <= remaining_next;
         timed_out <= timed_out_next;
         mem_we    <= mem_we_next;
         mem_addr  <= mem_addr_next;
         mem_din   <= mem_din_next;
         done_wr   <= done_next;
         err_wr    <= err_next;
      end
   end

   // Next-state: abort on start_wr low beats a byte, a byte beats timeout
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (start_wr) next_state = S_GET_ADDR;
         S_GET_ADDR: if (!start_wr) next_state = S_IDLE;
                     else if (rxrdy) next_state = S_GET_LEN;
                     else if (expired) next_state = S_DONE;
         S_GET_LEN:  if (!start_wr) next_state = S_IDLE;
                     else if (rxrdy) next_state = S_GET_DATA;
                     else if (expired) next_state = S_DONE;
         S_GET_DATA: if (!start_wr) next_state = S_IDLE;
                     else if (rxrdy) begin
                        if (remaining == 9'd1) next_state = S_DONE;
                     end else if (expired) next_state = S_DONE;
         S_DONE:     next_state = S_REARM;
         S_REARM:    if (!start_wr) next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   // Next values of the datapath and the registered outputs
   always_comb begin
      ptr_next       = ptr;
      remaining_next = remaining;
      timed_out_next = timed_out;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr;
      mem_din_next   = mem_din;
      done_next      = 1'b0;
      err_next       = 1'b0;
      case (state)
         S_IDLE: timed_out_next = 1'b0;
         S_GET_ADDR: if (start_wr) begin
            if (rxrdy) ptr_next = addr_byte;
            else if (expired) timed_out_next = 1'b1;
         end
         S_GET_LEN: if (start_wr) begin
            if (rxrdy) remaining_next = (rxdw == 8'd0) ? 9'd256 : {1'b0, rxdw};
            else if (expired) timed_out_next = 1'b1;
         end
         S_GET_DATA: if (start_wr) begin
            if (rxrdy) begin
               mem_we_next    = 1'b1;
               mem_addr_next  = ptr;
               mem_din_next   = rxdw;
               ptr_next       = ptr + ADDR_W'(1);
               remaining_next = remaining - 9'd1;
            end else if (expired) begin
               timed_out_next = 1'b1;
            end
         end
         S_DONE: begin
            done_next = 1'b1;
            err_next  = timed_out;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_ctrl
// Description : Directed and randomized frames for mem_write_ctrl with a
//               frame-level model of the expected RAM writes and done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_ctrl;

   localparam int ADDR_W = 8;
   localparam int TMO    = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_wr = 1'b0;
   logic       rxrdy = 1'b0;
   logic [7:0] rxdw = 8'h00;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic       done_wr;
   logic       err_wr;

   int vectors = 0;
   int miscompares = 0;

   int   cyc = 0, last_rx = 0, start_cyc = 0, done_cyc = 0, n_done = 0, err_stray = 0;
   logic done_err = 1'b0, start_prev = 1'b0;
   logic [7:0] wa[$], wd[$], pay[$];

   mem_write_ctrl #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start_wr (start_wr),
      .rxrdy    (rxrdy),
      .rxdw     (rxdw),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .done_wr  (done_wr),
      .err_wr   (err_wr)
   );

   always #5 clk = ~clk;

   // Observe inputs and outputs mid-cycle, logging writes and done events
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rxrdy) last_rx = cyc;
      if (start_wr && !start_prev) start_cyc = cyc;
      start_prev = start_wr;
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_din);
      end
      if (done_wr) begin
         n_done   = n_done + 1;
         done_cyc = cyc;
         done_err = err_wr;
      end
      if (err_wr && !done_wr) err_stray = err_stray + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rxrdy = 1'b1;
      rxdw  = b;
      step(1);
      rxrdy = 1'b0;
      step(gap);
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      n_done   = 0;
      done_err = 1'b0;
      done_cyc = 0;
   endtask

   // Frame model: byte i of the payload lands at (addr + i) mod 256
   task automatic check_writes(input string tag, input logic [7:0] a, input int n);
      check({tag, "_nwr"}, wa.size(), n);
      for (int i = 0; i < n && i < wa.size(); i++) begin
         check({tag, "_addr"}, wa[i], (int'(a) + i) % 256);
         check({tag, "_data"}, wd[i], pay[i]);
      end
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] l, input int n, input int maxgap);
      clear_log();
      start_wr = 1'b1;
      step(1);
      send(a, $urandom_range(0, maxgap));
      send(l, $urandom_range(0, maxgap));
      for (int i = 0; i < n; i++) send(pay[i], (i == n - 1) ? 0 : $urandom_range(0, maxgap));
   endtask

   initial begin
      // Reset state
      step(3);
      check("reset_mem_we", mem_we, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_din", mem_din, 0);
      check("reset_done_wr", done_wr, 0);
      check("reset_err_wr", err_wr, 0);
      rst = 1'b0;
      step(2);

      // Bytes while idle are ignored
      clear_log();
      send(8'h0F, 0);
      send(8'h12, 0);
      step(2);
      check("idle_nwr", wa.size(), 0);
      check("idle_ndone", n_done, 0);

      // Basic back-to-back frame
      pay = '{8'hAA, 8'hBB, 8'hCC};
      run_frame(8'h10, 8'h03, 3, 0);
      step(4);
      check_writes("basic", 8'h10, 3);
      check("basic_ndone", n_done, 1);
      check("basic_err", done_err, 0);
      check("basic_done_lat", done_cyc - last_rx, 2);

      // Held start_wr after done must not retrigger
      clear_log();
      send(8'h55, 0);
      send(8'h01, 0);
      send(8'h77, 6);
      check("rearm_nwr", wa.size(), 0);
      check("rearm_ndone", n_done, 0);
      start_wr = 1'b0;
      step(2);
      pay = '{8'h5A, 8'hA5};
      run_frame(8'h80, 8'h02, 2, 1);
      step(4);
      check_writes("rearm_new", 8'h80, 2);
      check("rearm_new_ndone", n_done, 1);
      start_wr = 1'b0;
      step(2);

      // LEN=0 means 256 bytes, address wraps past 0xFF
      pay.delete();
      for (int i = 0; i < 256; i++) pay.push_back(8'(i));
      run_frame(8'hFF, 8'h00, 256, 2);
      step(4);
      check_writes("wrap", 8'hFF, 256);
      check("wrap_ndone", n_done, 1);
      check("wrap_err", done_err, 0);
      start_wr = 1'b0;
      step(2);

      // Timeout inside the payload
      pay = '{8'h31, 8'h32};
      run_frame(8'h20, 8'h04, 2, 1);
      step(TMO + 10);
      check_writes("tmo", 8'h20, 2);
      check("tmo_ndone", n_done, 1);
      check("tmo_err", done_err, 1);
      check("tmo_lat", done_cyc - last_rx, TMO);
      start_wr = 1'b0;
      step(2);

      // Timeout counted from frame start with no bytes at all
      clear_log();
      start_wr = 1'b1;
      step(TMO + 10);
      check("tmo_start_lat", done_cyc - start_cyc, TMO);
      check("tmo_start_err", done_err, 1);
      check("tmo_start_nwr", wa.size(), 0);
      start_wr = 1'b0;
      step(2);

      // A byte arriving in the last cycle before expiry is still taken
      clear_log();
      pay = '{8'h99};
      start_wr = 1'b1;
      step(1);
      send(8'h60, TMO - 3);
      send(8'h01, 0);
      send(8'h99, 0);
      step(4);
      check_writes("edge", 8'h60, 1);
      check("edge_ndone", n_done, 1);
      check("edge_err", done_err, 0);
      start_wr = 1'b0;
      step(2);

      // Reset during payload drops the pending write
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_frame(8'h40, 8'h05, 2, 0);
      rxrdy = 1'b1;
      rxdw  = 8'h03;
      rst   = 1'b1;
      step(1);
      rxrdy = 1'b0;
      rst = 1'b0;
      start_wr = 1'b0;
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_done", done_wr, 0);
      step(5);
      check_writes("rst", 8'h40, 2);
      check("rst_ndone", n_done, 0);

      // Abort in GET_LEN
      clear_log();
      start_wr = 1'b1;
      step(1);
      send(8'h30, 0);
      start_wr = 1'b0;
      step(1);
      send(8'h02, 0);
      send(8'hAB, 0);
      send(8'hCD, 3);
      check("abort_len_nwr", wa.size(), 0);
      check("abort_len_ndone", n_done, 0);

      // start_wr low together with the last data byte: abort wins
      pay = '{8'h11, 8'h22};
      run_frame(8'h50, 8'h02, 1, 0);
      rxrdy = 1'b1;
      rxdw = 8'h22;
      start_wr = 1'b0;
      step(1);
      rxrdy = 1'b0;
      step(4);
      check_writes("abort_last", 8'h50, 1);
      check("abort_last_ndone", n_done, 0);

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         logic [7:0] a;
         int l;
         a = 8'($urandom);
         l = $urandom_range(1, 24);
         pay.delete();
         for (int i = 0; i < l; i++) pay.push_back(8'($urandom));
         run_frame(a, 8'(l), l, 3);
         step(4);
         check_writes("rand", a, l);
         check("rand_ndone", n_done, 1);
         check("rand_err", done_err, 0);
         start_wr = 1'b0;
         step(2);
      end

      check("err_without_done", err_stray, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
